// File: rtl/result_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : result_uart_tx_if
// Description : Push-side and status signals of the result UART transmitter.
//               The master side pushes bytes and observes the status flags
//               and the serial line; the slave side is the transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface result_uart_tx_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic       busy;
    logic       overflow;
    logic       tx;

    modport master (
        output wr_en, wr_data,
        input  full, empty, busy, overflow, tx
    );

    modport slave (
        input  wr_en, wr_data,
        output full, empty, busy, overflow, tx
    );
endinterface
`default_nettype wire

// File: rtl/result_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : result_uart_tx
// Description : Small byte FIFO feeding an 8N1 UART serializer. Frames are
//               sent back to back while the FIFO holds data. Define the macro
//               RESULT_UART_PARITY_EN to add an even-parity bit (8E1 frames).
// Revision    : 1.0 - initial release
// ============================================================================
module result_uart_tx #(
    parameter int CLKS_PER_BIT = 521,
    parameter int DEPTH        = 4
) (
    input  wire logic      clk,
    input  wire logic      reset,
    result_uart_tx_if.slave bus
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef RESULT_UART_PARITY_EN
        , S_PARITY = 3'd4
`endif
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          overflow;

    // Serializer state
    state_t        state;
    state_t        state_nxt;
    logic [15:0]   timer;
    logic [15:0]   timer_nxt;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_nxt;
    logic [7:0]    shreg;
    logic [7:0]    shreg_nxt;
    logic          tx_q;
    logic          tx_nxt;
    logic          bit_last;

    // Full is taken from the count at the start of the cycle, so a pop in the
    // same cycle never makes room for a push.
    assign fifo_full  = (count == DEPTH_CNT);
    assign fifo_empty = (count == '0);
    assign push       = bus.wr_en & ~fifo_full;
    assign bit_last   = (timer == BIT_LAST);

    assign bus.full     = fifo_full;
    assign bus.empty    = fifo_empty;
    assign bus.busy     = (state != S_IDLE);
    assign bus.overflow = overflow;
    assign bus.tx       = tx_q;

    // FIFO data array; writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
            if (bus.wr_en && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Serializer registers; reset aborts any frame and idles the line high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            bit_idx <= bit_nxt;
            shreg   <= shreg_nxt;
            tx_q    <= tx_nxt;
        end
    end

    // Serializer next state, bit timing and FIFO pop decision.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        bit_nxt   = bit_idx;
        shreg_nxt = shreg;
        tx_nxt    = tx_q;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shreg_nxt = mem[rd_ptr];
                    state_nxt = S_START;
                    tx_nxt    = 1'b0;
                    timer_nxt = '0;
                    bit_nxt   = '0;
                end
            end
            S_START: begin
                if (bit_last) begin
                    timer_nxt = '0;
                    state_nxt = S_DATA;
                    tx_nxt    = shreg[0];
                end else begin
                    timer_nxt = timer + 16'd1;
                end
            end
            S_DATA: begin
                if (bit_last) begin
                    timer_nxt = '0;
                    if (bit_idx == 3'd7) begin
`ifdef RESULT_UART_PARITY_EN
                        state_nxt = S_PARITY;
                        tx_nxt    = ^shreg;
`else
                        state_nxt = S_STOP;
                        tx_nxt    = 1'b1;
`endif
                    end else begin
                        bit_nxt = bit_idx + 3'd1;
                        tx_nxt  = shreg[bit_idx + 3'd1];
                    end
                end else begin
                    timer_nxt = timer + 16'd1;
                end
            end
`ifdef RESULT_UART_PARITY_EN
            S_PARITY: begin
                if (bit_last) begin
                    timer_nxt = '0;
                    state_nxt = S_STOP;
                    tx_nxt    = 1'b1;
                end else begin
                    timer_nxt = timer + 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (bit_last) begin
                    timer_nxt = '0;
                    // Chain straight into the next frame when data is waiting.
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shreg_nxt = mem[rd_ptr];
                        state_nxt = S_START;
                        tx_nxt    = 1'b0;
                        bit_nxt   = '0;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    timer_nxt = timer + 16'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                tx_nxt    = 1'b1;
                timer_nxt = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_result_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_uart_tx
// Description : Self-checking bench for result_uart_tx (CLKS_PER_BIT=4,
//               DEPTH=4). A queue-based frame model predicts the serial line
//               and flags every cycle; directed literal frames pin the model.
//               Honours RESULT_UART_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef RESULT_UART_PARITY_EN
    localparam int NB    = 11;
`else
    localparam int NB    = 10;
`endif
    localparam int FC    = NB * CPB;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    int   cyc;
    bit   chk_en;

    result_uart_tx_if bus ();

    result_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .DEPTH       (DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  m_q[$];
    bit          m_active;
    int          m_pos;
    logic [10:0] m_frame;
    bit          m_ovf;
    bit          m_full0;

    function automatic logic [10:0] make_frame(input logic [7:0] b);
`ifdef RESULT_UART_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b0, 1'b1, b, 1'b0};
`endif
    endfunction

    // Model step at each edge: frame progress, pop of waiting byte, then push.
    always @(posedge clk) begin
        if (!reset) begin
            m_q.delete();
            m_active = 1'b0;
            m_pos    = 0;
            m_ovf    = 1'b0;
        end else begin
            m_full0 = (m_q.size() == DEPTH);
            if (m_active) begin
                m_pos++;
                if (m_pos == FC) m_active = 1'b0;
            end
            if (!m_active && m_q.size() != 0) begin
                m_frame  = make_frame(m_q.pop_front());
                m_pos    = 0;
                m_active = 1'b1;
            end
            if (bus.wr_en) begin
                if (m_full0) m_ovf = 1'b1;
                else         m_q.push_back(bus.wr_data);
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("tx",       bus.tx,       m_active ? m_frame[m_pos / CPB] : 1'b1);
            chk("busy",     bus.busy,     m_active);
            chk("empty",    bus.empty,    m_q.size() == 0);
            chk("full",     bus.full,     m_q.size() == DEPTH);
            chk("overflow", bus.overflow, m_ovf);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!bus.busy && bus.empty) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("idle_timeout", done, 1'b1);
    endtask

    task automatic run_literal(input logic [7:0] b, input logic [10:0] frame);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        @(negedge clk);
        bus.wr_en = 1'b0;
        for (int k = 1; k <= FC + 1; k++) begin
            @(negedge clk);
            if (k <= FC) chk("lit_tx", bus.tx, frame[(k - 1) / CPB]);
            chk("lit_busy", bus.busy, k <= FC);
            if (k == 1) chk("lit_empty", bus.empty, 1'b1);
        end
    endtask

    task automatic busy_run(output int n);
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit hit;
        tests       = 0;
        fails       = 0;
        cyc         = 0;
        chk_en      = 1'b0;
        reset       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_tx",       bus.tx,       1'b1);
        chk("rst_busy",     bus.busy,     1'b0);
        chk("rst_empty",    bus.empty,    1'b1);
        chk("rst_full",     bus.full,     1'b0);
        chk("rst_overflow", bus.overflow, 1'b0);
        chk_en = 1'b1;
        reset  = 1'b1;
        repeat (2) @(negedge clk);

        // Literal frames: 0xA5 and 0x07 (parity of 0xA5 is 0, of 0x07 is 1).
`ifdef RESULT_UART_PARITY_EN
        run_literal(8'hA5, 11'b1_0_1010_0101_0);
        run_literal(8'h07, 11'b1_1_0000_0111_0);
`else
        run_literal(8'hA5, 11'b0_1_1010_0101_0);
        run_literal(8'h07, 11'b0_1_0000_0111_0);
`endif
        wait_idle();

        // Three consecutive pushes: one unbroken busy stretch of three frames.
        for (int i = 1; i <= 3; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(i);
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
        busy_run(n);
        chk("b2b_len", n, 3 * FC - 2);
        wait_idle();

        // Six consecutive pushes: full after the fifth, sixth dropped.
        for (int i = 0; i < 6; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'h30 + 8'(i);
            @(negedge clk);
            if (i == 4) chk("full_5th", bus.full, 1'b1);
        end
        bus.wr_en = 1'b0;
        chk("ovf_6th", bus.overflow, 1'b1);
        busy_run(n);
        chk("five_frames_len", n, 5 * FC - 5);
        chk("ovf_sticky", bus.overflow, 1'b1);
        wait_idle();

        // Reset during data bit 3 with a second byte queued.
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h3C;
        @(negedge clk);
        bus.wr_data = 8'h99;
        @(negedge clk);
        bus.wr_en = 1'b0;
        repeat (17) @(negedge clk);
        reset       = 1'b0;
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'hEE;
        @(negedge clk);
        reset     = 1'b1;
        bus.wr_en = 1'b0;
        chk("midrst_tx",    bus.tx,       1'b1);
        chk("midrst_busy",  bus.busy,     1'b0);
        chk("midrst_empty", bus.empty,    1'b1);
        chk("midrst_ovf",   bus.overflow, 1'b0);
        repeat (60) @(negedge clk);
        chk("midrst_quiet", bus.busy, 1'b0);

        // Push while full in the very cycle a pop happens: still dropped.
        for (int i = 0; i < 5; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'hC0 + 8'(i);
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (m_active && m_pos == FC - 1 && m_q.size() == DEPTH) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("pop_edge_found", hit, 1'b1);
        chk("pre_ovf", bus.overflow, 1'b0);
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h55;
        @(negedge clk);
        bus.wr_en = 1'b0;
        chk("popfull_ovf",  bus.overflow, 1'b1);
        chk("popfull_full", bus.full,     1'b0);
        wait_idle();

        // Randomized traffic with alternating light/heavy load and rare resets.
        for (int seg = 0; seg < 6; seg++) begin
            for (int i = 0; i < 600; i++) begin
                bus.wr_en   = ($urandom_range(0, 99) < ((seg % 2) ? 45 : 4));
                bus.wr_data = 8'($urandom_range(0, 255));
                reset       = ($urandom_range(0, 799) != 0);
                @(negedge clk);
            end
        end
        bus.wr_en = 1'b0;
        reset     = 1'b1;
        wait_idle();
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/result_uart_tx.md
RESULT_UART_TX -- requirements
Module: result_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 521, clocks per serial bit (5 MHz clk_5 at 9600 baud); legal range 2..65535.
REQ-002 The block SHALL have parameter DEPTH, default 4, FIFO entries; legal values are powers of two from 2 to 16.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge active.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port wr_en, input, 1 bit: push request from the CPU result path (show qualified by step clock).
REQ-006 The block SHALL have port wr_data, input, 8 bits: the byte to transmit (ALU res / r1).
REQ-007 The block SHALL have port full, output, 1 bit: the FIFO holds DEPTH entries.
REQ-008 The block SHALL have port empty, output, 1 bit: the FIFO holds 0 entries.
REQ-009 The block SHALL have port busy, output, 1 bit: the serializer is outside IDLE.
REQ-010 The block SHALL have port overflow, output, 1 bit: sticky flag set when a push is dropped.
REQ-011 The block SHALL have port tx, output, 1 bit: registered serial line driving o_TXD1; idle level is high.

Function
REQ-012 On the rising clk edge where wr_en=1 and full=0, wr_data SHALL be written at the write pointer and count SHALL increment.
REQ-013 A wr_en=1 while full=1 SHALL drop the byte, leave the FIFO unchanged, and set overflow=1 on that edge; full is evaluated from the count at the start of the cycle, even if a pop occurs in the same cycle.
REQ-014 A push and a pop in the same cycle SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-015 The serializer SHALL implement states IDLE, START, DATA, PARITY (macro-dependent), and STOP, with a bit-timer counting 0..CLKS_PER_BIT-1 and a 3-bit bit index.
REQ-016 In IDLE with empty=0, the serializer SHALL pop the head byte into a shift register, enter START, and drive tx<=0 on the same edge.
REQ-017 Latency: a byte pushed into an empty FIFO with the serializer IDLE at edge N SHALL produce tx=0 from edge N+1.
REQ-018 START SHALL last CLKS_PER_BIT cycles, then the block SHALL enter DATA.
REQ-019 DATA SHALL send 8 bits LSB first, each held CLKS_PER_BIT cycles.
REQ-020 After bit 7, the block SHALL enter PARITY if enabled, otherwise STOP.
REQ-021 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles; at its last cycle, if empty=0 the block SHALL pop and go directly to START with no idle gap, otherwise it SHALL go to IDLE.
REQ-022 wr_en and wr_data SHALL be ignored for the frame already in progress; in-flight frame contents are fixed at pop.
REQ-023 busy SHALL be 1 in every state except IDLE.

Reset
REQ-024 When reset=0 at a clk edge, the block SHALL apply: state=IDLE, tx=1, FIFO pointers and count=0, empty=1, full=0, busy=0, overflow=0, timers=0.
REQ-025 A reset asserted mid-frame SHALL abort the frame immediately (tx=1 on that edge) and discard all FIFO contents.
REQ-026 A wr_en coincident with reset=0 SHALL be ignored.

Configuration
REQ-027 When macro RESULT_UART_PARITY_EN is defined, the PARITY state SHALL be present and send the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles between DATA and STOP, giving an 11-bit frame.
REQ-028 When RESULT_UART_PARITY_EN is undefined, the PARITY state SHALL NOT exist and frames SHALL be 8N1, 10 bits.

Verification (CLKS_PER_BIT=4, DEPTH=4)
REQ-029 Push 0xA5 at edge N with the FIFO idle -> tx=0 for cycles N+1..N+4, then 1,0,1,0,0,1,0,1 at 4 cycles each, then tx=1 for 4 cycles; busy falls at N+41; empty=1 from N+1.
REQ-030 Push 0x01,0x02,0x03 on consecutive edges -> three back-to-back 40-cycle frames with no idle cycle between them; bytes are received in order.
REQ-031 Push 6 bytes on consecutive edges while a frame is active -> full=1 after the 5th push (1 in flight + 4 queued); the 6th is dropped with overflow=1 sticky; exactly 5 frames are sent.
REQ-032 Assert reset=0 for one cycle during DATA bit 3 -> tx=1, busy=0, empty=1 on that edge; no further frame is sent.
REQ-033 With RESULT_UART_PARITY_EN defined, push 0x07 -> parity bit=1 precedes the stop bit; the frame is 44 cycles long.
REQ-034 At full with a pop occurring in the same cycle, push 0x55 -> the byte is dropped and overflow=1 (REQ-013).
